// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the EX/MEM pipeline buffer
package pipe_pkg;

  localparam int P_DATA_W  = 8;
  localparam int P_MADDR_W = 4;
  localparam int P_REG_AW  = 3;
  localparam int P_OPC_W   = 4;

  localparam logic [P_OPC_W-1:0] OPC_LOAD = 4'b0100;

  typedef struct packed {
    logic                 valid;
    logic [P_DATA_W-1:0]  result;
    logic [P_DATA_W-1:0]  load_result;
    logic [P_MADDR_W-1:0] mem_addr;
    logic [P_REG_AW-1:0]  opa_adr;
    logic [P_OPC_W-1:0]   opcode;
    logic                 reg_we;
    logic                 mem_we;
    logic [P_REG_AW-1:0]  dest_reg;
  } exmem_bundle_t;

endpackage

// File: rtl/fwd_lookup.sv
// rtl/fwd_lookup.sv - priority forwarding match across all in-flight stages
module fwd_lookup
  import pipe_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  exmem_bundle_t         stage [DEPTH],
  input  logic [P_REG_AW-1:0]   src,
  output logic                  hit,
  output logic [P_DATA_W-1:0]   data
);

  // Walk oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (stage[i].valid && stage[i].reg_we && (stage[i].dest_reg == src)) begin
        hit  = 1'b1;
        data = (stage[i].opcode == OPC_LOAD) ? stage[i].load_result : stage[i].result;
      end
    end
  end

endmodule

// File: rtl/ex_mem_pipe.sv
// rtl/ex_mem_pipe.sv - DEPTH-stage EX/MEM buffer with stall, flush, occupancy and forwarding
module ex_mem_pipe
  import pipe_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int MADDR_W = 4,
  parameter int REG_AW  = 3,
  parameter int OPC_W   = 4,
  parameter int DEPTH   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_result,
  input  logic [DATA_W-1:0]          in_load_result,
  input  logic [MADDR_W-1:0]         in_mem_addr,
  input  logic [REG_AW-1:0]          in_opa_adr,
  input  logic [OPC_W-1:0]           in_opcode,
  input  logic                       in_reg_we,
  input  logic                       in_mem_we,
  input  logic [REG_AW-1:0]          in_dest_reg,
  input  logic                       stall,
  input  logic                       flush,
  input  logic [REG_AW-1:0]          fwd_src_a,
  input  logic [REG_AW-1:0]          fwd_src_b,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_result,
  output logic [DATA_W-1:0]          out_load_result,
  output logic [MADDR_W-1:0]         out_mem_addr,
  output logic [REG_AW-1:0]          out_opa_adr,
  output logic [OPC_W-1:0]           out_opcode,
  output logic                       out_reg_we,
  output logic                       out_mem_we,
  output logic [REG_AW-1:0]          out_dest_reg,
  output logic                       fwd_hit_a,
  output logic                       fwd_hit_b,
  output logic [DATA_W-1:0]          fwd_data_a,
  output logic [DATA_W-1:0]          fwd_data_b,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  exmem_bundle_t stage [DEPTH];
  exmem_bundle_t in_b;

  always_comb begin
    in_b             = '0;
    in_b.valid       = in_valid;
    in_b.result      = in_result;
    in_b.load_result = in_load_result;
    in_b.mem_addr    = in_mem_addr;
    in_b.opa_adr     = in_opa_adr;
    in_b.opcode      = in_opcode;
    in_b.reg_we      = in_reg_we;
    in_b.mem_we      = in_mem_we;
    in_b.dest_reg    = in_dest_reg;
  end

  // Flush outranks stall; occupancy tracks the popcount of stage valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      occupancy <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      occupancy <= '0;
    end else if (!stall) begin
      stage[0] <= in_b;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      occupancy <= occupancy - OCC_W'(stage[DEPTH-1].valid) + OCC_W'(in_valid);
    end
  end

  assign out_valid       = stage[DEPTH-1].valid;
  assign out_result      = stage[DEPTH-1].result;
  assign out_load_result = stage[DEPTH-1].load_result;
  assign out_mem_addr    = stage[DEPTH-1].mem_addr;
  assign out_opa_adr     = stage[DEPTH-1].opa_adr;
  assign out_opcode      = stage[DEPTH-1].opcode;
  assign out_reg_we      = stage[DEPTH-1].reg_we & stage[DEPTH-1].valid;
  assign out_mem_we      = stage[DEPTH-1].mem_we & stage[DEPTH-1].valid;
  assign out_dest_reg    = stage[DEPTH-1].dest_reg;

  fwd_lookup #(.DEPTH(DEPTH)) u_fwd_a (
    .stage (stage),
    .src   (fwd_src_a),
    .hit   (fwd_hit_a),
    .data  (fwd_data_a)
  );

  fwd_lookup #(.DEPTH(DEPTH)) u_fwd_b (
    .stage (stage),
    .src   (fwd_src_b),
    .hit   (fwd_hit_b),
    .data  (fwd_data_b)
  );

endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb/tb_ex_mem_pipe.sv - directed self-checking bench for ex_mem_pipe at DEPTH 2 and 4
module tb_ex_mem_pipe;

  logic       clk, rst_n;
  logic       in_valid, in_reg_we, in_mem_we, stall, flush;
  logic [7:0] in_result, in_load_result;
  logic [3:0] in_mem_addr, in_opcode;
  logic [2:0] in_opa_adr, in_dest_reg, fwd_src_a, fwd_src_b;

  logic       o2_valid, o2_reg_we, o2_mem_we, h2a, h2b;
  logic [7:0] o2_result, o2_load_result, d2a, d2b;
  logic [3:0] o2_mem_addr, o2_opcode;
  logic [2:0] o2_opa_adr, o2_dest_reg;
  logic [1:0] occ2;

  logic       o4_valid, o4_reg_we, o4_mem_we, h4a, h4b;
  logic [7:0] o4_result, o4_load_result, d4a, d4b;
  logic [3:0] o4_mem_addr, o4_opcode;
  logic [2:0] o4_opa_adr, o4_dest_reg;
  logic [2:0] occ4;

  int checks = 0;
  int failures = 0;

  ex_mem_pipe #(.DEPTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_result(in_result),
    .in_load_result(in_load_result), .in_mem_addr(in_mem_addr), .in_opa_adr(in_opa_adr),
    .in_opcode(in_opcode), .in_reg_we(in_reg_we), .in_mem_we(in_mem_we),
    .in_dest_reg(in_dest_reg), .stall(stall), .flush(flush),
    .fwd_src_a(fwd_src_a), .fwd_src_b(fwd_src_b),
    .out_valid(o2_valid), .out_result(o2_result), .out_load_result(o2_load_result),
    .out_mem_addr(o2_mem_addr), .out_opa_adr(o2_opa_adr), .out_opcode(o2_opcode),
    .out_reg_we(o2_reg_we), .out_mem_we(o2_mem_we), .out_dest_reg(o2_dest_reg),
    .fwd_hit_a(h2a), .fwd_hit_b(h2b), .fwd_data_a(d2a), .fwd_data_b(d2b),
    .occupancy(occ2)
  );

  ex_mem_pipe #(.DEPTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_result(in_result),
    .in_load_result(in_load_result), .in_mem_addr(in_mem_addr), .in_opa_adr(in_opa_adr),
    .in_opcode(in_opcode), .in_reg_we(in_reg_we), .in_mem_we(in_mem_we),
    .in_dest_reg(in_dest_reg), .stall(stall), .flush(flush),
    .fwd_src_a(fwd_src_a), .fwd_src_b(fwd_src_b),
    .out_valid(o4_valid), .out_result(o4_result), .out_load_result(o4_load_result),
    .out_mem_addr(o4_mem_addr), .out_opa_adr(o4_opa_adr), .out_opcode(o4_opcode),
    .out_reg_we(o4_reg_we), .out_mem_we(o4_mem_we), .out_dest_reg(o4_dest_reg),
    .fwd_hit_a(h4a), .fwd_hit_b(h4b), .fwd_data_a(d4a), .fwd_data_b(d4b),
    .occupancy(occ4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_result = '0; in_load_result = '0; in_mem_addr = '0;
    in_opa_adr = '0; in_opcode = '0; in_reg_we = 1'b0; in_mem_we = 1'b0;
    in_dest_reg = '0; stall = 1'b0; flush = 1'b0;
  endtask

  task automatic drive(input logic [7:0] res, input logic [7:0] lres, input logic [2:0] dest,
                       input logic [3:0] opc, input logic rwe, input logic mwe);
    in_valid = 1'b1; in_result = res; in_load_result = lres; in_mem_addr = res[3:0];
    in_opa_adr = dest + 3'd1; in_opcode = opc; in_reg_we = rwe; in_mem_we = mwe;
    in_dest_reg = dest;
  endtask

  task automatic test_reset();
    checks++; if (o2_valid !== 1'b0) begin failures++; $display("FAIL reset_valid2 got=%b exp=0", o2_valid); end
    checks++; if (o2_result !== 8'h00) begin failures++; $display("FAIL reset_result2 got=%h exp=00", o2_result); end
    checks++; if (o2_reg_we !== 1'b0 || o2_mem_we !== 1'b0) begin failures++; $display("FAIL reset_we2 got=%b%b exp=00", o2_reg_we, o2_mem_we); end
    checks++; if (occ2 !== 2'd0) begin failures++; $display("FAIL reset_occ2 got=%0d exp=0", occ2); end
    checks++; if (occ4 !== 3'd0) begin failures++; $display("FAIL reset_occ4 got=%0d exp=0", occ4); end
    checks++; if (h2a !== 1'b0 || d2a !== 8'h00) begin failures++; $display("FAIL reset_fwd2 got=%b/%h exp=0/00", h2a, d2a); end
  endtask

  task automatic test_basic();
    drive(8'h5A, 8'h00, 3'd3, 4'h1, 1'b1, 1'b0);
    tick();
    checks++; if (occ2 !== 2'd1) begin failures++; $display("FAIL basic_occ_e1 got=%0d exp=1", occ2); end
    checks++; if (o2_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_e1 got=%b exp=0", o2_valid); end
    drive(8'h6B, 8'h00, 3'd4, 4'h2, 1'b1, 1'b0);
    tick();
    idle();
    checks++; if (o2_result !== 8'h5A) begin failures++; $display("FAIL basic_result_e2 got=%h exp=5a", o2_result); end
    checks++; if (o2_reg_we !== 1'b1 || o2_dest_reg !== 3'd3) begin failures++; $display("FAIL basic_we_dest_e2 got=%b/%0d exp=1/3", o2_reg_we, o2_dest_reg); end
    checks++; if (occ2 !== 2'd2) begin failures++; $display("FAIL basic_occ_e2 got=%0d exp=2", occ2); end
    tick();
    checks++; if (o2_result !== 8'h6B || o2_valid !== 1'b1) begin failures++; $display("FAIL basic_result_e3 got=%h/%b exp=6b/1", o2_result, o2_valid); end
    checks++; if (occ2 !== 2'd1) begin failures++; $display("FAIL basic_occ_e3 got=%0d exp=1", occ2); end
    tick();
    checks++; if (occ2 !== 2'd0 || o2_valid !== 1'b0) begin failures++; $display("FAIL basic_drain got=%0d/%b exp=0/0", occ2, o2_valid); end
  endtask

  task automatic test_stall();
    idle();
    tick(); tick();
    drive(8'h3C, 8'h00, 3'd5, 4'h3, 1'b1, 1'b1);
    tick();
    stall = 1'b1;
    drive(8'hB0, 8'h00, 3'd6, 4'h3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (o2_valid !== 1'b0) begin failures++; $display("FAIL stall_hold_valid[%0d] got=%b exp=0", i, o2_valid); end
      checks++; if (occ2 !== 2'd1) begin failures++; $display("FAIL stall_hold_occ[%0d] got=%0d exp=1", i, occ2); end
    end
    idle();
    tick();
    checks++; if (o2_valid !== 1'b1 || o2_result !== 8'h3C) begin failures++; $display("FAIL stall_release got=%b/%h exp=1/3c", o2_valid, o2_result); end
    checks++; if (o2_mem_we !== 1'b1 || o2_mem_addr !== 4'hC) begin failures++; $display("FAIL stall_release_mem got=%b/%h exp=1/c", o2_mem_we, o2_mem_addr); end
    checks++; if (occ2 !== 2'd1) begin failures++; $display("FAIL stall_release_occ got=%0d exp=1", occ2); end
    tick();
  endtask

  task automatic test_flush();
    idle();
    tick();
    drive(8'h41, 8'h00, 3'd1, 4'h5, 1'b0, 1'b1);
    tick();
    drive(8'h42, 8'h00, 3'd2, 4'h5, 1'b0, 1'b1);
    tick();
    checks++; if (o2_mem_we !== 1'b1 || occ2 !== 2'd2) begin failures++; $display("FAIL flush_pre got=%b/%0d exp=1/2", o2_mem_we, occ2); end
    drive(8'hEE, 8'hEE, 3'd7, 4'h6, 1'b1, 1'b1);
    stall = 1'b1;
    flush = 1'b1;
    tick();
    idle();
    checks++; if (o2_valid !== 1'b0 || o2_result !== 8'h00 || o2_dest_reg !== 3'd0) begin failures++; $display("FAIL flush_out got=%b/%h/%0d exp=0/00/0", o2_valid, o2_result, o2_dest_reg); end
    checks++; if (o2_mem_we !== 1'b0 || o2_reg_we !== 1'b0) begin failures++; $display("FAIL flush_we got=%b%b exp=00", o2_mem_we, o2_reg_we); end
    checks++; if (occ2 !== 2'd0 || occ4 !== 3'd0) begin failures++; $display("FAIL flush_occ got=%0d/%0d exp=0/0", occ2, occ4); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (o2_valid !== 1'b0 || o2_result !== 8'h00 || o2_mem_we !== 1'b0) begin failures++; $display("FAIL flush_dropped[%0d] got=%b/%h/%b exp=0/00/0", i, o2_valid, o2_result, o2_mem_we); end
    end
  endtask

  task automatic test_forwarding();
    idle();
    drive(8'h22, 8'h00, 3'd2, 4'h0, 1'b1, 1'b0);
    tick();
    drive(8'h11, 8'h00, 3'd2, 4'h0, 1'b1, 1'b0);
    tick();
    idle();
    stall = 1'b1;
    fwd_src_a = 3'd2;
    fwd_src_b = 3'd3;
    #1;
    checks++; if (h2a !== 1'b1 || d2a !== 8'h11) begin failures++; $display("FAIL fwd_youngest got=%b/%h exp=1/11", h2a, d2a); end
    checks++; if (h2b !== 1'b0 || d2b !== 8'h00) begin failures++; $display("FAIL fwd_nomatch got=%b/%h exp=0/00", h2b, d2b); end
    stall = 1'b0;
    drive(8'h99, 8'h77, 3'd2, 4'b0100, 1'b1, 1'b0);
    tick();
    idle();
    stall = 1'b1;
    fwd_src_b = 3'd2;
    #1;
    checks++; if (h2a !== 1'b1 || d2a !== 8'h77) begin failures++; $display("FAIL fwd_load got=%b/%h exp=1/77", h2a, d2a); end
    checks++; if (h2b !== 1'b1 || d2b !== 8'h77) begin failures++; $display("FAIL fwd_load_b got=%b/%h exp=1/77", h2b, d2b); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    stall = 1'b0;
    drive(8'h99, 8'h77, 3'd2, 4'b0100, 1'b0, 1'b0);
    tick();
    idle();
    stall = 1'b1;
    #1;
    checks++; if (h2a !== 1'b0 || d2a !== 8'h00) begin failures++; $display("FAIL fwd_no_we got=%b/%h exp=0/00", h2a, d2a); end
    stall = 1'b0;
    drive(8'h05, 8'h00, 3'd0, 4'h1, 1'b1, 1'b0);
    tick();
    idle();
    stall = 1'b1;
    fwd_src_b = 3'd0;
    #1;
    checks++; if (h2b !== 1'b1 || d2b !== 8'h05) begin failures++; $display("FAIL fwd_reg0 got=%b/%h exp=1/05", h2b, d2b); end
    idle();
    fwd_src_a = 3'd0;
    fwd_src_b = 3'd0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_res;
    int exp_occ;
    idle();
    flush = 1'b1;
    tick();
    idle();
    for (int k = 0; k < 14; k++) begin
      if (k < 10) drive(8'h10 + 8'(k), 8'h00, 3'(k), 4'h1, 1'b1, 1'b0);
      else idle();
      tick();
      exp_occ = 0;
      for (int j = k - 3; j <= k; j++) if (j >= 0 && j <= 9) exp_occ++;
      checks++; if (occ4 !== 3'(exp_occ)) begin failures++; $display("FAIL b2b_occ[%0d] got=%0d exp=%0d", k, occ4, exp_occ); end
      if (k >= 3 && k <= 12) begin
        exp_res = 8'h10 + 8'(k - 3);
        checks++; if (o4_valid !== 1'b1 || o4_result !== exp_res || o4_dest_reg !== 3'(k - 3)) begin failures++; $display("FAIL b2b_out[%0d] got=%b/%h/%0d exp=1/%h/%0d", k, o4_valid, o4_result, o4_dest_reg, exp_res, 3'(k - 3)); end
      end else begin
        checks++; if (o4_valid !== 1'b0) begin failures++; $display("FAIL b2b_gap[%0d] got=%b exp=0", k, o4_valid); end
      end
    end
  endtask

  task automatic test_reset_mid();
    idle();
    flush = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      drive(8'hA0 + 8'(i), 8'h00, 3'd6, 4'h1, 1'b1, 1'b0);
      tick();
    end
    idle();
    fwd_src_a = 3'd6;
    #1;
    checks++; if (occ4 !== 3'd3 || h4a !== 1'b1 || d4a !== 8'hA2) begin failures++; $display("FAIL rstmid_pre got=%0d/%b/%h exp=3/1/a2", occ4, h4a, d4a); end
    checks++; if (o2_valid !== 1'b1 || o2_result !== 8'hA1) begin failures++; $display("FAIL rstmid_pre2 got=%b/%h exp=1/a1", o2_valid, o2_result); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (occ4 !== 3'd0 || h4a !== 1'b0 || d4a !== 8'h00) begin failures++; $display("FAIL rstmid_async4 got=%0d/%b/%h exp=0/0/00", occ4, h4a, d4a); end
    checks++; if (o2_valid !== 1'b0 || o2_result !== 8'h00 || occ2 !== 2'd0) begin failures++; $display("FAIL rstmid_async2 got=%b/%h/%0d exp=0/00/0", o2_valid, o2_result, occ2); end
    #1 rst_n = 1'b1;
    drive(8'hB5, 8'h00, 3'd6, 4'h1, 1'b1, 1'b0);
    tick();
    idle();
    checks++; if (occ4 !== 3'd1) begin failures++; $display("FAIL rstmid_resume_occ got=%0d exp=1", occ4); end
    tick(); tick(); tick();
    checks++; if (o4_valid !== 1'b1 || o4_result !== 8'hB5 || o4_reg_we !== 1'b1) begin failures++; $display("FAIL rstmid_resume_out got=%b/%h/%b exp=1/b5/1", o4_valid, o4_result, o4_reg_we); end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    fwd_src_a = 3'd0;
    fwd_src_b = 3'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    test_reset();
    test_basic();
    test_stall();
    test_flush();
    test_forwarding();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
